vnu: RTL and testbench
======================

# vnu

Serial min-sum variable node unit: the variable-side counterpart of `cnu` in the LDPC decoder message loop. It accepts the D check-to-variable messages for one variable node, one per handshake, and adds them to the channel LLR. It then returns D extrinsic variable-to-check messages, `q_k = total - r_k`, one per handshake, plus a hard-decision bit. Its outputs feed `cnu`'s `q` input after the interleaver.

## Interface
Parameters:
- `data_w`, 8: message width (two's complement); same as `cnu`.
- `D`, 3: variable node degree (≥1).
- `acc_w`, 12: accumulator width; must be ≥ `data_w + clog2(D+1)`.
- `idx_w`, 8: width of the message index output.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `llr`  in  data_w  channel LLR; sampled only on the first accepted `r` beat of a block.
- `r_in`  in  data_w  check-to-variable message.
- `r_valid`  in  1  `r_in` valid.
- `r_ready`  out  1  VNU accepts `r_in` (registered).
- `q_out`  out  data_w  variable-to-check message.
- `q_idx`  out  idx_w  index k (0..D-1) of `q_out`.
- `q_valid`  out  1  `q_out`/`q_idx` valid (registered).
- `q_ready`  in  1  downstream accepts `q_out`.
- `hd`  out  1  hard decision: 1 when total < 0.
- `hd_valid`  out  1  one-cycle pulse when `hd` updates.

## Operation
- Handshakes: an input beat occurs when `r_valid & r_ready`; an output beat occurs when `q_valid & q_ready`.
- Storage:
  - `acc` (acc_w, signed).
  - `buf[0..D-1]` (data_w).
  - Input counter `cnt` and output counter `k`.
- FSM states: IDLE, ACCUM, EMIT.
- IDLE:
  - `r_ready`=1.
  - On a beat: `acc` ← sext(`llr`) + sext(`r_in`), `buf[0]` ← `r_in`, `cnt` ← 1.
  - Next state is ACCUM, or EMIT if D==1.
- ACCUM:
  - `r_ready`=1.
  - Each beat: `acc` += sext(`r_in`), `buf[cnt]` ← `r_in`, `cnt`++.
  - The beat with `cnt`==D-1 moves to EMIT and clears `r_ready` at the same edge.
  - Cycles without `r_valid` are bubbles; `acc` is unchanged.
- Entry to EMIT: `k` ← 0, `q_valid` ← 1, `hd` ← sign(final acc), `hd_valid` pulses for 1 cycle.
- EMIT:
  - `q_out` = fmt(`acc` − sext(`buf[k]`)), computed in acc_w+1 bits; `q_idx` = k.
  - Each output beat increments k.
  - The output beat with k==D-1 clears `q_valid`, sets `r_ready` and returns to IDLE at the same edge.
- `r_valid` during EMIT is not accepted. `llr` is ignored on every beat except the first.
- `hd` holds its value until the next block's entry to EMIT.
- fmt is saturate or wrap; see Configuration.

## Timing
- Reset (asynchronous on assertion) forces:
  - state IDLE, `acc`/`cnt`/`k`/`buf` = 0;
  - `r_ready`=0, `q_valid`=0, `q_out`=0, `q_idx`=0, `hd`=0, `hd_valid`=0.
- `r_ready` rises at the first rising `clk` edge after `rst` deasserts.
- Latency: first `q_valid` appears in the cycle after the last input beat.
- Minimum block period: 2·D cycles (D input beats + D output beats, no overlap).
- While `q_valid`=1 and `q_ready`=0, `q_out`, `q_idx` and `q_valid` hold stable.
- `q_ready` high with `q_valid` low has no effect.
- Reset mid-block discards all partial state; the next block starts clean.

## Configuration
- `VNU_SAT_EN` defined:
  - fmt clamps to the symmetric range [−(2^(data_w−1)−1), +(2^(data_w−1)−1)], i.e. ±127 for data_w=8.
  - The most-negative code is never emitted, so `cnu`'s magnitude path never overflows.
- `VNU_SAT_EN` undefined: fmt takes the low `data_w` bits (two's-complement wrap), with no clamp logic.
- `hd` always uses the unformatted `acc` sign in both builds.

## Test plan
- D=3, `llr`=10, r=5,−3,7, `q_ready`=1 → `q_out`=14,22,12 with `q_idx`=0,1,2; `hd`=0 with a 1-cycle `hd_valid`; `r_ready` returns to 1 after the idx 2 beat.
- `llr`=100, r=100,100,100 → each q=300: with `VNU_SAT_EN` → 127,127,127; without → 44,44,44. `llr`=−128, r=−128×3 → each q=−384: with → −127; without → −128.
- `llr`=−20, r=2,3,4 → `hd`=1; `q_out`=−13,−14,−15.
- Backpressure: `q_ready`=0 for 3 cycles at idx 1 → `q_out`=22, `q_idx`=1 held stable; `r_ready` stays 0; `r_valid`=1 is not accepted.
- Input bubbles: r=5, gap 2 cycles, −3, gap 1 cycle, 7 → results identical to the first scenario; `llr` changed during the gaps is ignored.
- Assert `rst` after the idx 0 output beat → `q_valid`=0 immediately. After release: `r_ready`=1 at the next edge, and block `llr`=1, r=1,1,1 gives `q_out`=3,3,3 with no residue.

Source files
------------

// File: rtl/vnu.sv
// Serial min-sum variable node unit: accumulates D check messages onto the channel LLR,
// then emits D extrinsic messages q_k = total - r_k. Define VNU_SAT_EN for symmetric saturation.
module vnu #(
    parameter int data_w = 8,
    parameter int D      = 3,
    parameter int acc_w  = 12,
    parameter int idx_w  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [data_w-1:0] llr,
    input  logic signed [data_w-1:0] r_in,
    input  logic                     r_valid,
    output logic                     r_ready,
    output logic signed [data_w-1:0] q_out,
    output logic        [idx_w-1:0]  q_idx,
    output logic                     q_valid,
    input  logic                     q_ready,
    output logic                     hd,
    output logic                     hd_valid
);

    localparam int cnt_w = (D > 1) ? $clog2(D) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic signed [acc_w-1:0]   acc_q, acc_d;
    logic signed [data_w-1:0]  buf_q [D];
    logic signed [data_w-1:0]  buf_d [D];
    logic        [cnt_w-1:0]   cnt_q, cnt_d;
    logic        [cnt_w-1:0]   k_q, k_d;
    logic                      r_ready_q, r_ready_d;
    logic                      q_valid_q, q_valid_d;
    logic                      hd_q, hd_d;
    logic                      hd_valid_q, hd_valid_d;
    logic                      beat_in, beat_out;
    logic signed [data_w-1:0]  q_fmt;

    assign beat_in  = r_valid & r_ready_q;
    assign beat_out = q_valid_q & q_ready;

    // NOTE: every variable assigned in this block gets a default first, so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        hd_d       = hd_q;
        hd_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (beat_in) begin
                    acc_d    = acc_w'(llr) + acc_w'(r_in);
                    buf_d[0] = r_in;
                    cnt_d    = cnt_w'(1);
                    state_d  = (D == 1) ? EMIT : ACCUM;
                end
            end
            ACCUM: begin
                if (beat_in) begin
                    acc_d        = acc_q + acc_w'(r_in);
                    buf_d[cnt_q] = r_in;
                    cnt_d        = cnt_q + cnt_w'(1);
                    if (cnt_q == cnt_w'(D - 1)) state_d = EMIT;
                end
            end
            EMIT: begin
                if (beat_out) begin
                    if (k_q == cnt_w'(D - 1)) begin
                        state_d = IDLE;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + cnt_w'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Hard decision is taken from the unformatted total at the moment it is complete.
        if (state_q != EMIT && state_d == EMIT) begin
            k_d        = '0;
            hd_d       = acc_d[acc_w-1];
            hd_valid_d = 1'b1;
        end

        r_ready_d = (state_d != EMIT);
        q_valid_d = (state_d == EMIT);
    end

`ifdef VNU_SAT_EN
    localparam logic signed [data_w-1:0] q_max = {1'b0, {(data_w-1){1'b1}}};
    localparam logic signed [data_w-1:0] q_min = -q_max;

    logic signed [acc_w:0] diff;

    always_comb begin
        diff = (acc_w+1)'(acc_q) - (acc_w+1)'(buf_q[k_q]);
        if (diff > (acc_w+1)'(q_max))      q_fmt = q_max;
        else if (diff < (acc_w+1)'(q_min)) q_fmt = q_min;
        else                               q_fmt = diff[data_w-1:0];
    end
`else
    // Wrapping keeps only the low bits, so the subtraction can be done at message width.
    always_comb begin
        q_fmt = acc_q[data_w-1:0] - buf_q[k_q];
    end
`endif

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            k_q        <= '0;
            r_ready_q  <= 1'b0;
            q_valid_q  <= 1'b0;
            hd_q       <= 1'b0;
            hd_valid_q <= 1'b0;
            // NOTE: the message buffer is reset too, so an aborted block leaves no residue.
            for (int i = 0; i < D; i++) buf_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            r_ready_q  <= r_ready_d;
            q_valid_q  <= q_valid_d;
            hd_q       <= hd_d;
            hd_valid_q <= hd_valid_d;
            for (int i = 0; i < D; i++) buf_q[i] <= buf_d[i];
        end
    end

    assign r_ready  = r_ready_q;
    assign q_valid  = q_valid_q;
    assign q_out    = q_valid_q ? q_fmt : '0;
    assign q_idx    = idx_w'(k_q);
    assign hd       = hd_q;
    assign hd_valid = hd_valid_q;

endmodule

// File: tb/tb_vnu.sv
// Self-checking bench for vnu (D=3, data_w=8): scoreboard of expected q messages per block.
module tb_vnu;

    logic              clk = 1'b0;
    logic              rst;
    logic signed [7:0] llr;
    logic signed [7:0] r_in;
    logic              r_valid;
    logic              r_ready;
    logic signed [7:0] q_out;
    logic        [7:0] q_idx;
    logic              q_valid;
    logic              q_ready;
    logic              hd;
    logic              hd_valid;

    vnu #(.data_w(8), .D(3), .acc_w(12), .idx_w(8)) dut (
        .clk(clk), .rst(rst), .llr(llr), .r_in(r_in), .r_valid(r_valid),
        .r_ready(r_ready), .q_out(q_out), .q_idx(q_idx), .q_valid(q_valid),
        .q_ready(q_ready), .hd(hd), .hd_valid(hd_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [7:0] q;
        logic        [7:0] idx;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic signed [7:0] fmt_model(input int v);
        logic [31:0] t;
        t = v;
`ifdef VNU_SAT_EN
        if (v > 127)  return 8'sd127;
        if (v < -127) return -8'sd127;
`endif
        return t[7:0];
    endfunction

    // Drives one block and consumes n_out output beats, optionally stalling at stall_k.
    task automatic run_block(input string name, input int llr_v, input int r0, input int r1,
                             input int r2, input int gap0, input int gap1,
                             input int stall_k, input int stall_n, input int n_out);
        int   rv[3];
        int   gaps[3];
        int   total;
        logic exp_hd;
        exp_t e;
        rv    = '{r0, r1, r2};
        gaps  = '{gap0, gap1, 0};
        total = llr_v + r0 + r1 + r2;
        exp_hd = (total < 0);
        for (int i = 0; i < 3; i++) begin
            e.q   = fmt_model(total - rv[i]);
            e.idx = 8'(i);
            sb.push_back(e);
        end

        for (int i = 0; i < 3; i++) begin
            int t = 0;
            while (!r_ready && t < 20) begin
                @(posedge clk); #1; t++;
            end
            if (!r_ready) begin
                n_checks++;
                $display("FAIL %s_r_ready_timeout: r_ready=%b want 1 at beat %0d", name, r_ready, i);
                sb.delete();
                return;
            end
            llr     = (i == 0) ? 8'(llr_v) : 8'($urandom);
            r_in    = 8'(rv[i]);
            r_valid = 1'b1;
            @(posedge clk); #1;
            r_valid = 1'b0;
            llr     = 8'($urandom);
            repeat (gaps[i]) begin
                @(posedge clk); #1;
                llr = 8'($urandom);
            end
        end

        n_checks++; if (q_valid !== 1'b1) $display("FAIL %s_latency_q_valid: got %b want 1", name, q_valid); else n_pass++;
        n_checks++; if (hd_valid !== 1'b1) $display("FAIL %s_hd_valid_pulse: got %b want 1", name, hd_valid); else n_pass++;
        n_checks++; if (hd !== exp_hd) $display("FAIL %s_hd: got %b want %b", name, hd, exp_hd); else n_pass++;
        n_checks++; if (r_ready !== 1'b0) $display("FAIL %s_r_ready_emit: got %b want 0", name, r_ready); else n_pass++;

        for (int k = 0; k < n_out; k++) begin
            if (k == stall_k) begin
                q_ready = 1'b0;
                r_valid = 1'b1;
                r_in    = 8'sd99;
                repeat (stall_n) begin
                    @(posedge clk); #1;
                    n_checks++; if (q_valid !== 1'b1) $display("FAIL %s_stall_q_valid: got %b want 1", name, q_valid); else n_pass++;
                    n_checks++; if (q_idx !== 8'(k)) $display("FAIL %s_stall_q_idx: got %0d want %0d", name, q_idx, k); else n_pass++;
                    n_checks++; if (q_out !== sb[0].q) $display("FAIL %s_stall_q_out: got %0d want %0d", name, q_out, sb[0].q); else n_pass++;
                    n_checks++; if (r_ready !== 1'b0) $display("FAIL %s_stall_r_ready: got %b want 0", name, r_ready); else n_pass++;
                end
                r_valid = 1'b0;
            end
            q_ready = 1'b1;
            e = sb.pop_front();
            n_checks++; if (q_valid !== 1'b1) $display("FAIL %s_q_valid_k%0d: got %b want 1", name, k, q_valid); else n_pass++;
            n_checks++; if (q_out !== e.q) $display("FAIL %s_q_out_k%0d: got %0d want %0d", name, k, q_out, e.q); else n_pass++;
            n_checks++; if (q_idx !== e.idx) $display("FAIL %s_q_idx_k%0d: got %0d want %0d", name, k, q_idx, e.idx); else n_pass++;
            @(posedge clk); #1;
            if (k == 0) begin
                n_checks++; if (hd_valid !== 1'b0) $display("FAIL %s_hd_valid_one_cycle: got %b want 0", name, hd_valid); else n_pass++;
            end
        end

        if (n_out == 3) begin
            n_checks++; if (r_ready !== 1'b1) $display("FAIL %s_r_ready_return: got %b want 1", name, r_ready); else n_pass++;
            n_checks++; if (q_valid !== 1'b0) $display("FAIL %s_q_valid_done: got %b want 0", name, q_valid); else n_pass++;
            n_checks++; if (hd !== exp_hd) $display("FAIL %s_hd_hold: got %b want %b", name, hd, exp_hd); else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; r_valid = 1'b0; q_ready = 1'b1; llr = '0; r_in = '0;
        #12;
        n_checks++; if (r_ready !== 1'b0) $display("FAIL reset_r_ready: got %b want 0", r_ready); else n_pass++;
        n_checks++; if (q_valid !== 1'b0) $display("FAIL reset_q_valid: got %b want 0", q_valid); else n_pass++;
        n_checks++; if (q_out !== 8'sd0) $display("FAIL reset_q_out: got %0d want 0", q_out); else n_pass++;
        n_checks++; if (q_idx !== 8'd0) $display("FAIL reset_q_idx: got %0d want 0", q_idx); else n_pass++;
        n_checks++; if (hd !== 1'b0 || hd_valid !== 1'b0) $display("FAIL reset_hd: got %b/%b want 0/0", hd, hd_valid); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (r_ready !== 1'b0) $display("FAIL reset_release_r_ready: got %b want 0", r_ready); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (r_ready !== 1'b1) $display("FAIL reset_first_edge_r_ready: got %b want 1", r_ready); else n_pass++;
    endtask

    task automatic test_basic();
        run_block("basic", 10, 5, -3, 7, 0, 0, -1, 0, 3);
    endtask

    task automatic test_saturation();
        run_block("big_pos", 100, 100, 100, 100, 0, 0, -1, 0, 3);
        run_block("big_neg", -128, -128, -128, -128, 0, 0, -1, 0, 3);
    endtask

    task automatic test_hd_negative();
        run_block("hd_neg", -20, 2, 3, 4, 0, 0, -1, 0, 3);
    endtask

    task automatic test_backpressure();
        run_block("backpressure", 10, 5, -3, 7, 0, 0, 1, 3, 3);
    endtask

    task automatic test_bubbles();
        run_block("bubbles", 10, 5, -3, 7, 2, 1, -1, 0, 3);
    endtask

    task automatic test_back_to_back();
        run_block("b2b_a", 50, -60, 20, 33, 0, 0, -1, 0, 3);
        run_block("b2b_b", -5, 1, -1, 4, 0, 0, 0, 1, 3);
    endtask

    task automatic test_reset_mid_block();
        run_block("pre_reset", 10, 5, -3, 7, 0, 0, -1, 0, 1);
        sb.delete();
        rst = 1'b0;
        #1;
        n_checks++; if (q_valid !== 1'b0) $display("FAIL midreset_q_valid: got %b want 0", q_valid); else n_pass++;
        n_checks++; if (r_ready !== 1'b0) $display("FAIL midreset_r_ready: got %b want 0", r_ready); else n_pass++;
        n_checks++; if (q_idx !== 8'd0) $display("FAIL midreset_q_idx: got %0d want 0", q_idx); else n_pass++;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (r_ready !== 1'b1) $display("FAIL midreset_release_r_ready: got %b want 1", r_ready); else n_pass++;
        run_block("post_reset", 1, 1, 1, 1, 0, 0, -1, 0, 3);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_hd_negative();
        test_backpressure();
        test_bubbles();
        test_back_to_back();
        test_reset_mid_block();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
